unified_mem_arbiter: RTL and testbench

- Shares one single-port synchronous unified memory between the instruction-fetch requester (read only) and the data-memory requester (load/store).
- Sits between the fetch stage, the memory stage and the memory macro.
- Sequences each access through a fixed-latency request/response FSM and drives per-port stall signals back to the pipeline.
- Data port has priority; a streak counter prevents fetch starvation.

---
 rtl/unified_mem_arbiter_if.sv | 52 +++++
 rtl/unified_mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/unified_mem_arbiter_if.sv
// Bundles the fetch, data and memory-macro signals of the unified memory arbiter.
// The master view belongs to the arbiter; the slave view belongs to the pipeline and memory.
interface unified_mem_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  localparam int unsigned BE_W = DATA_WIDTH / 8;

  logic                  IFReq_i;
  logic [ADDR_WIDTH-1:0] IFAddr_i;
  logic                  IFKill_i;
  logic [DATA_WIDTH-1:0] IFRdata_o;
  logic                  IFValid_o;

  logic                  DMReq_i;
  logic                  DMWrite_i;
  logic [ADDR_WIDTH-1:0] DMAddr_i;
  logic [DATA_WIDTH-1:0] DMWdata_i;
  logic [BE_W-1:0]       DMByteEn_i;
  logic [DATA_WIDTH-1:0] DMRdata_o;
  logic                  DMValid_o;

  logic                  MemReq_o;
  logic                  MemWe_o;
  logic [ADDR_WIDTH-1:0] MemAddr_o;
  logic [DATA_WIDTH-1:0] MemWdata_o;
  logic [BE_W-1:0]       MemByteEn_o;
  logic [DATA_WIDTH-1:0] MemRdata_i;

  logic                  StallF_o;
  logic                  StallM_o;

  modport master (
    input  IFReq_i, IFAddr_i, IFKill_i,
    output IFRdata_o, IFValid_o,
    input  DMReq_i, DMWrite_i, DMAddr_i, DMWdata_i, DMByteEn_i,
    output DMRdata_o, DMValid_o,
    output MemReq_o, MemWe_o, MemAddr_o, MemWdata_o, MemByteEn_o,
    input  MemRdata_i,
    output StallF_o, StallM_o
  );

  modport slave (
    output IFReq_i, IFAddr_i, IFKill_i,
    input  IFRdata_o, IFValid_o,
    output DMReq_i, DMWrite_i, DMAddr_i, DMWdata_i, DMByteEn_i,
    input  DMRdata_o, DMValid_o,
    input  MemReq_o, MemWe_o, MemAddr_o, MemWdata_o, MemByteEn_o,
    output MemRdata_i,
    input  StallF_o, StallM_o
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbitrates fetch and data accesses onto one single-port fixed-latency memory.
// Data wins ties; a grant streak counter forces a fetch after STARVE_LIMIT data grants.
module unified_mem_arbiter #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned MEM_LATENCY  = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  unified_mem_arbiter_if.master bus
);
  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int unsigned STK_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [STK_W-1:0]      streak_q, streak_d;
  logic                  kill_q, kill_d;
  logic                  win_if_q, win_if_d;
  logic                  win_wr_q, win_wr_d;

  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]       mem_be_q, mem_be_d;

  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic                  if_valid_q, if_valid_d;
  logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
  logic                  dm_valid_q, dm_valid_d;

  logic                  if_req;
  logic                  grant_if;
  logic                  grant_wr;
  logic                  kill_now;

  // Next-state, arbitration and payload capture
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    streak_d    = streak_q;
    kill_d      = kill_q;
    win_if_d    = win_if_q;
    win_wr_d    = win_wr_q;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    mem_be_d    = '0;
    if_rdata_d  = if_rdata_q;
    if_valid_d  = 1'b0;
    dm_rdata_d  = dm_rdata_q;
    dm_valid_d  = 1'b0;
    if_req      = bus.IFReq_i & ~bus.IFKill_i;
    grant_if    = 1'b0;
    grant_wr    = 1'b0;
    kill_now    = kill_q | (win_if_q & bus.IFKill_i);

    unique case (state_q)
      S_IDLE: begin
        kill_d = 1'b0;
        if (!bus.IFReq_i) streak_d = '0;
        if (bus.DMReq_i || if_req) begin
          grant_if    = if_req && (!bus.DMReq_i || streak_q == STK_W'(STARVE_LIMIT));
          grant_wr    = !grant_if && bus.DMWrite_i;
          win_if_d    = grant_if;
          win_wr_d    = grant_wr;
          mem_req_d   = 1'b1;
          mem_we_d    = grant_wr;
          mem_addr_d  = grant_if ? bus.IFAddr_i : bus.DMAddr_i;
          mem_wdata_d = grant_wr ? bus.DMWdata_i : '0;
          mem_be_d    = grant_wr ? bus.DMByteEn_i : '1;
          if (grant_if) begin
            streak_d = '0;
          end else if (bus.IFReq_i && streak_q != STK_W'(STARVE_LIMIT)) begin
            streak_d = streak_q + STK_W'(1);
          end
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        kill_d  = kill_now;
        cnt_d   = CNT_W'(MEM_LATENCY - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        kill_d = kill_now;
        if (cnt_q == '0) begin
          // Read data is valid this cycle; a late kill still suppresses the fetch result
          if (win_if_q) begin
            if (!kill_now) begin
              if_rdata_d = bus.MemRdata_i;
              if_valid_d = 1'b1;
            end
          end else begin
            dm_valid_d = 1'b1;
            if (!win_wr_q) dm_rdata_d = bus.MemRdata_i;
          end
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        kill_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset drops any in-flight response
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      streak_q    <= '0;
      kill_q      <= 1'b0;
      win_if_q    <= 1'b0;
      win_wr_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      dm_rdata_q  <= '0;
      dm_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      streak_q    <= streak_d;
      kill_q      <= kill_d;
      win_if_q    <= win_if_d;
      win_wr_q    <= win_wr_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_rdata_q  <= if_rdata_d;
      if_valid_q  <= if_valid_d;
      dm_rdata_q  <= dm_rdata_d;
      dm_valid_q  <= dm_valid_d;
    end
  end

  assign bus.MemReq_o    = mem_req_q;
  assign bus.MemWe_o     = mem_we_q;
  assign bus.MemAddr_o   = mem_addr_q;
  assign bus.MemWdata_o  = mem_wdata_q;
  assign bus.MemByteEn_o = mem_be_q;
  assign bus.IFRdata_o   = if_rdata_q;
  assign bus.IFValid_o   = if_valid_q;
  assign bus.DMRdata_o   = dm_rdata_q;
  assign bus.DMValid_o   = dm_valid_q;

  assign bus.StallF_o = ~rst & bus.IFReq_i & ~if_valid_q;
  assign bus.StallM_o = ~rst & bus.DMReq_i & ~dm_valid_q;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter with a two-cycle-latency read memory model.
module tb_unified_mem_arbiter;
  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 32;
  localparam int unsigned LAT = 2;
  localparam int unsigned SL  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  unified_mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  unified_mem_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LATENCY(LAT), .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h100: mem_rd = 32'hDEAD_BEEF;
      32'h104: mem_rd = 32'h1111_2222;
      32'h400: mem_rd = 32'hCAFE_0001;
      32'h404: mem_rd = 32'hCAFE_0002;
      32'h408: mem_rd = 32'hCAFE_0003;
      32'h40C: mem_rd = 32'hCAFE_0004;
      default: mem_rd = 32'h5A5A_5A5A;
    endcase
  endfunction

  // Read data appears exactly two cycles after the issue cycle; junk otherwise
  logic [31:0] pipe0, pipe1;
  always @(posedge clk) begin
    pipe0 <= (bus.MemReq_o && !bus.MemWe_o) ? mem_rd(bus.MemAddr_o) : 32'hBAD0_BAD0;
    pipe1 <= pipe0;
  end
  assign bus.MemRdata_i = pipe1;

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.IFReq_i = 1'b1;  bus.IFAddr_i = '0;  bus.IFKill_i = 1'b0;
    bus.DMReq_i = 1'b1;  bus.DMWrite_i = 1'b0; bus.DMAddr_i = '0;
    bus.DMWdata_i = '0;  bus.DMByteEn_i = '0;
    repeat (3) next();
    chk("rst_memreq",  32'(bus.MemReq_o), 32'd0);
    chk("rst_memwe",   32'(bus.MemWe_o), 32'd0);
    chk("rst_memaddr", bus.MemAddr_o, 32'd0);
    chk("rst_membe",   32'(bus.MemByteEn_o), 32'd0);
    chk("rst_ifvalid", 32'(bus.IFValid_o), 32'd0);
    chk("rst_dmvalid", 32'(bus.DMValid_o), 32'd0);
    chk("rst_ifrdata", bus.IFRdata_o, 32'd0);
    chk("rst_dmrdata", bus.DMRdata_o, 32'd0);
    chk("rst_stallf",  32'(bus.StallF_o), 32'd0);
    chk("rst_stallm",  32'(bus.StallM_o), 32'd0);
    bus.IFReq_i = 1'b0; bus.DMReq_i = 1'b0; rst = 1'b0;
    next(); next();

    // Single load
    next(); bus.DMReq_i = 1'b1; bus.DMAddr_i = 32'h100; #1;
    chk("ld_stallm_t0", 32'(bus.StallM_o), 32'd1);
    chk("ld_memreq_t0", 32'(bus.MemReq_o), 32'd0);
    next();
    chk("ld_memreq",  32'(bus.MemReq_o), 32'd1);
    chk("ld_memaddr", bus.MemAddr_o, 32'h100);
    chk("ld_memwe",   32'(bus.MemWe_o), 32'd0);
    chk("ld_membe",   32'(bus.MemByteEn_o), 32'hF);
    next();
    chk("ld_memreq_t2", 32'(bus.MemReq_o), 32'd0);
    next();
    chk("ld_dmvalid_t3", 32'(bus.DMValid_o), 32'd0);
    chk("ld_stallm_t3",  32'(bus.StallM_o), 32'd1);
    next();
    chk("ld_dmvalid", 32'(bus.DMValid_o), 32'd1);
    chk("ld_dmrdata", bus.DMRdata_o, 32'hDEAD_BEEF);
    chk("ld_stallm_t4", 32'(bus.StallM_o), 32'd0);
    next(); bus.DMReq_i = 1'b0; #1;
    chk("ld_dmvalid_t5", 32'(bus.DMValid_o), 32'd0);
    chk("ld_dmrdata_hold", bus.DMRdata_o, 32'hDEAD_BEEF);

    // Store with partial byte enables
    next();
    bus.DMReq_i = 1'b1; bus.DMWrite_i = 1'b1; bus.DMAddr_i = 32'h200;
    bus.DMWdata_i = 32'h1234_5678; bus.DMByteEn_i = 4'b0011;
    next();
    chk("st_memreq",   32'(bus.MemReq_o), 32'd1);
    chk("st_memwe",    32'(bus.MemWe_o), 32'd1);
    chk("st_memaddr",  bus.MemAddr_o, 32'h200);
    chk("st_memwdata", bus.MemWdata_o, 32'h1234_5678);
    chk("st_membe",    32'(bus.MemByteEn_o), 32'h3);
    repeat (3) next();
    chk("st_dmvalid", 32'(bus.DMValid_o), 32'd1);
    chk("st_dmrdata", bus.DMRdata_o, 32'hDEAD_BEEF);
    next();
    bus.DMReq_i = 1'b0; bus.DMWrite_i = 1'b0; bus.DMWdata_i = '0; bus.DMByteEn_i = '0;

    // Contention: data first, fetch issued six cycles after the request
    next();
    bus.IFReq_i = 1'b1; bus.IFAddr_i = 32'h400;
    bus.DMReq_i = 1'b1; bus.DMAddr_i = 32'h104; #1;
    chk("ct_stallf_t0", 32'(bus.StallF_o), 32'd1);
    next();
    chk("ct_first_addr", bus.MemAddr_o, 32'h104);
    repeat (3) next();
    chk("ct_dmvalid", 32'(bus.DMValid_o), 32'd1);
    chk("ct_dmrdata", bus.DMRdata_o, 32'h1111_2222);
    chk("ct_ifvalid_t4", 32'(bus.IFValid_o), 32'd0);
    next(); bus.DMReq_i = 1'b0;
    next();
    chk("ct_if_memreq", 32'(bus.MemReq_o), 32'd1);
    chk("ct_if_addr",   bus.MemAddr_o, 32'h400);
    chk("ct_if_we",     32'(bus.MemWe_o), 32'd0);
    chk("ct_if_be",     32'(bus.MemByteEn_o), 32'hF);
    repeat (3) next();
    chk("ct_ifvalid", 32'(bus.IFValid_o), 32'd1);
    chk("ct_ifrdata", bus.IFRdata_o, 32'hCAFE_0001);
    chk("ct_stallf_t9", 32'(bus.StallF_o), 32'd0);
    next(); bus.IFReq_i = 1'b0;

    // Kill during WAIT, then a kill in IDLE masks one request cycle
    next(); bus.IFReq_i = 1'b1; bus.IFAddr_i = 32'h404;
    next();
    chk("kl_addr", bus.MemAddr_o, 32'h404);
    next(); bus.IFKill_i = 1'b1;
    next(); bus.IFKill_i = 1'b0; bus.IFReq_i = 1'b0;
    next();
    chk("kl_ifvalid", 32'(bus.IFValid_o), 32'd0);
    chk("kl_ifrdata", bus.IFRdata_o, 32'hCAFE_0001);
    next(); bus.IFReq_i = 1'b1; bus.IFAddr_i = 32'h408; bus.IFKill_i = 1'b1;
    next();
    chk("kl_idle_mask", 32'(bus.MemReq_o), 32'd0);
    bus.IFKill_i = 1'b0;
    next();
    chk("kl_re_memreq", 32'(bus.MemReq_o), 32'd1);
    chk("kl_re_addr",   bus.MemAddr_o, 32'h408);
    repeat (3) next();
    chk("kl_re_valid", 32'(bus.IFValid_o), 32'd1);
    chk("kl_re_rdata", bus.IFRdata_o, 32'hCAFE_0003);
    next(); bus.IFReq_i = 1'b0;

    // Starvation: four data grants, then the held fetch is forced
    next();
    bus.IFReq_i = 1'b1; bus.IFAddr_i = 32'h40C;
    bus.DMReq_i = 1'b1; bus.DMAddr_i = 32'h100;
    for (int k = 0; k < 4; k++) begin
      next();
      chk($sformatf("str_dm_issue%0d", k), bus.MemAddr_o, 32'h100);
      repeat (3) next();
      chk($sformatf("str_dm_valid%0d", k), 32'(bus.DMValid_o), 32'd1);
      next();
    end
    next();
    chk("str_if_issue", bus.MemAddr_o, 32'h40C);
    repeat (3) next();
    chk("str_ifvalid", 32'(bus.IFValid_o), 32'd1);
    chk("str_ifrdata", bus.IFRdata_o, 32'hCAFE_0004);
    chk("str_dmvalid_off", 32'(bus.DMValid_o), 32'd0);
    next(); bus.IFReq_i = 1'b0;
    next();
    chk("str_dm_resume_req",  32'(bus.MemReq_o), 32'd1);
    chk("str_dm_resume_addr", bus.MemAddr_o, 32'h100);
    repeat (3) next();
    chk("str_dm_resume_valid", 32'(bus.DMValid_o), 32'd1);
    next(); bus.DMReq_i = 1'b0;

    // Reset during WAIT of a load
    next(); bus.DMReq_i = 1'b1; bus.DMAddr_i = 32'h100;
    next();
    next(); rst = 1'b1;
    next();
    chk("rs_memreq",  32'(bus.MemReq_o), 32'd0);
    chk("rs_dmvalid", 32'(bus.DMValid_o), 32'd0);
    chk("rs_dmrdata", bus.DMRdata_o, 32'd0);
    chk("rs_ifrdata", bus.IFRdata_o, 32'd0);
    chk("rs_stallm",  32'(bus.StallM_o), 32'd0);
    rst = 1'b0; #1;
    chk("rs_stallm_released", 32'(bus.StallM_o), 32'd1);
    next();
    chk("rs_fresh_issue", 32'(bus.MemReq_o), 32'd1);
    chk("rs_novalid_t1", 32'(bus.DMValid_o), 32'd0);
    next();
    chk("rs_novalid_t2", 32'(bus.DMValid_o), 32'd0);
    next();
    chk("rs_novalid_t3", 32'(bus.DMValid_o), 32'd0);
    next();
    chk("rs_dmvalid_fresh", 32'(bus.DMValid_o), 32'd1);
    chk("rs_dmrdata_fresh", bus.DMRdata_o, 32'hDEAD_BEEF);
    next(); bus.DMReq_i = 1'b0;
    repeat (3) next();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
